sbox_sched: RTL
===============

Name: sbox_sched

Overview:
- Time-shares one `sbox` instance between two requesters:
  - the round datapath, which needs SubBytes on a 128-bit state;
  - the key expansion, which needs SubWord on a 32-bit word.
- Each job is serialized one byte per cycle through the single S-box, which minimizes area for the FPGA/side-channel study build.
- Sits between the AES round controller, the key schedule and the shared S-box.

Parameters:
- ST_BYTES, 16, bytes per state job (fixed for AES-128; not overridden).
- KW_BYTES, 4, bytes per key-word job.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_req  in  1  state job request; held with st_in until st_ack.
- st_in  in  128  state; byte i = st_in[127-8i -: 8].
- st_ack  out  1  one-cycle pulse: st_in captured.
- st_done  out  1  one-cycle pulse: st_out valid.
- st_out  out  128  substituted state, same byte order; held until the next st job completes.
- kw_req  in  1  key-word job request; held with kw_in until kw_ack.
- kw_in  in  32  word; byte i = kw_in[31-8i -: 8].
- kw_ack  out  1  one-cycle pulse: kw_in captured.
- kw_done  out  1  one-cycle pulse: kw_out valid.
- kw_out  out  32  substituted word; held until the next kw job completes.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async, rst=1): FSM=IDLE; byte index=0; st_ack, kw_ack, st_done, kw_done, busy = 0; st_out, kw_out = 0; round-robin pointer favours kw.
- FSM states: IDLE, RUN_ST, RUN_KW, DONE_ST, DONE_KW.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the requester not served last; after reset, kw wins.
  - At the grant edge: capture input into a working register, pulse the matching ack in the next cycle, clear index, enter RUN_x.
  - A req seen in any state other than IDLE is ignored until IDLE. No preemption.
- RUN_x:
  - Each cycle, drive byte[index] into the sbox and write the sbox output into result byte[index]; index += 1.
  - After the last byte (index 15 for st, 3 for kw), go to DONE_x.
- DONE_x:
  - Update the x output register from the result; pulse x_done for one cycle; update the round-robin pointer.
  - Return to IDLE.
  - If x_req is high in that IDLE cycle, it is a new job.
- Latency, taking the grant edge as cycle 0: st_done is high in cycle 17; kw_done is high in cycle 5. Back-to-back throughput: one st job per 18 cycles, one kw job per 6 cycles.
- Requester rule: drop req in the cycle after observing ack. A req still high when the FSM returns to IDLE starts a duplicate job; this is legal and is the requester's responsibility.
- Reset mid-job:
  - Abort immediately; no done pulse.
  - Outputs return to 0.
  - A req still high after reset is serviced as a fresh job.
- Simultaneous requests: the loser's req must stay high. It is granted in the IDLE cycle after the winner's DONE.
- busy = (state != IDLE).

Optional Feature:
- Macro: `SBOX_SCHED_PIPE_EN`.
- When defined:
  - The sbox output is registered before write-back.
  - RUN_x lasts one extra cycle to drain the pipeline: the write for index k lands one cycle later.
  - Latency becomes st_done at cycle 18 and kw_done at cycle 6.
  - This shortens the critical path and separates S-box switching from result-register switching for trace studies.
- When undefined: combinational write-back with the latencies stated above.

Decomposition:
- Shared package `aes_pkg`:
  - byte/word/state width constants (8/32/128);
  - ST_BYTES and KW_BYTES;
  - the FSM state enum;
  - a requester-ID enum {REQ_ST, REQ_KW}.
- Sub-module: reuse the existing `sbox` (`originalByte` → `subbedByte`), one instance.
- No other sub-module. The arbiter is small enough to live inline in the FSM.

Test Plan:
- FIPS-197 App. B round-1 state:
  - Stimulus: st_req with st_in = 128'h193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: st_done at cycle 17 (cycle 18 with the pipe macro) and st_out = 128'hd42711aee0bf98f1b8b45de51e415230.
- Key word after RotWord:
  - Stimulus: kw_req with kw_in = 32'hcf4f3c09.
  - Required: kw_done at cycle 5 and kw_out = 32'h8a84eb01.
- Simultaneous requests:
  - Stimulus: st_req and kw_req asserted in the same cycle right after reset, both held until ack.
  - Required: kw is served first. st_ack occurs in the cycle after kw_done, and both results are correct.
  - Repeat the simultaneous request: st now wins (round-robin alternation).
- Ignored request:
  - Stimulus: st_req asserted during RUN_KW.
  - Required: no st_ack until IDLE, and kw_out is unaffected.
- Reset mid-job:
  - Stimulus: assert rst during the 8th byte of an st job with st_in = 0.
  - Required: immediate busy=0 and st_out=0, with no st_done pulse.
  - After rst is released and st_req re-asserted: st_out = 128'h63636363636363636363636363636363.
- Exhaustive:
  - Stimulus: 64 kw jobs covering bytes 00..ff (4 per job).
  - Required: each output byte matches the FIPS-197 S-box table.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, job sizes and enums for the serial S-box scheduler.
package aes_pkg;
    localparam int BYTE_W   = 8;
    localparam int WORD_W   = 32;
    localparam int STATE_W  = 128;
    localparam int ST_BYTES = 16;
    localparam int KW_BYTES = 4;
    typedef enum logic [2:0] {IDLE, RUN_ST, RUN_KW, DONE_ST, DONE_KW} sched_state_e;
    typedef enum logic {REQ_ST, REQ_KW} req_id_e;
endpackage

// File: rtl/sbox.sv
// sbox: AES forward S-box (FIPS-197), purely combinational table lookup.
module sbox (
    input  logic [7:0] originalByte,
    output logic [7:0] subbedByte
);
    localparam logic [0:255][7:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign subbedByte = SBOX_T[originalByte];
endmodule

// File: rtl/sbox_sched.sv
// sbox_sched: time-shares one S-box between state SubBytes and key SubWord jobs, one byte per cycle.
// Define SBOX_SCHED_PIPE_EN to register the S-box output before write-back (one extra cycle per job).
module sbox_sched
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               st_req,
    input  logic [STATE_W-1:0] st_in,
    output logic               st_ack,
    output logic               st_done,
    output logic [STATE_W-1:0] st_out,
    input  logic               kw_req,
    input  logic [WORD_W-1:0]  kw_in,
    output logic               kw_ack,
    output logic               kw_done,
    output logic [WORD_W-1:0]  kw_out,
    output logic               busy
);
    sched_state_e                   state_q, state_d;
    req_id_e                        last_q, last_d;
    logic [4:0]                     idx_q, idx_d, last_idx;
    logic [ST_BYTES-1:0][BYTE_W-1:0] work_q, work_d;
    logic [STATE_W-1:0]             st_out_q, st_out_d;
    logic [WORD_W-1:0]              kw_out_q, kw_out_d;
    logic                           st_ack_q, st_ack_d, kw_ack_q, kw_ack_d;
    logic                           st_done_q, st_done_d, kw_done_q, kw_done_d;
    logic [3:0]                     rd_sel;
    logic [BYTE_W-1:0]              sb_out;
    logic                           grant_kw;

    // Byte i lives in element 15-i; key words occupy the top four elements.
    assign rd_sel   = ~idx_q[3:0];
    assign grant_kw = kw_req && (!st_req || last_q == REQ_ST);

`ifdef SBOX_SCHED_PIPE_EN
    logic [BYTE_W-1:0] sb_q, sb_d;
    logic [3:0]        wr_sel;
    assign sb_d     = sb_out;
    assign wr_sel   = ~(idx_q[3:0] - 4'd1);
    assign last_idx = (state_q == RUN_ST) ? 5'(ST_BYTES) : 5'(KW_BYTES);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sb_q <= '0;
        else sb_q <= sb_d;
    end
`else
    assign last_idx = (state_q == RUN_ST) ? 5'(ST_BYTES - 1) : 5'(KW_BYTES - 1);
`endif

    sbox u_sbox (
        .originalByte(work_q[rd_sel]),
        .subbedByte  (sb_out)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        idx_d     = idx_q;
        work_d    = work_q;
        st_out_d  = st_out_q;
        kw_out_d  = kw_out_q;
        st_ack_d  = 1'b0;
        kw_ack_d  = 1'b0;
        st_done_d = 1'b0;
        kw_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (grant_kw) begin
                    state_d  = RUN_KW;
                    work_d   = {kw_in, 96'b0};
                    kw_ack_d = 1'b1;
                end else if (st_req) begin
                    state_d  = RUN_ST;
                    work_d   = st_in;
                    st_ack_d = 1'b1;
                end
            end
            RUN_ST, RUN_KW: begin
                idx_d = idx_q + 5'd1;
`ifdef SBOX_SCHED_PIPE_EN
                if (idx_q != 5'd0) work_d[wr_sel] = sb_q;
`else
                work_d[rd_sel] = sb_out;
`endif
                if (idx_q == last_idx) state_d = (state_q == RUN_ST) ? DONE_ST : DONE_KW;
            end
            DONE_ST: begin
                st_out_d  = work_q;
                st_done_d = 1'b1;
                last_d    = REQ_ST;
                state_d   = IDLE;
            end
            DONE_KW: begin
                kw_out_d  = work_q[15:12];
                kw_done_d = 1'b1;
                last_d    = REQ_KW;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= REQ_ST;
            idx_q     <= '0;
            work_q    <= '0;
            st_out_q  <= '0;
            kw_out_q  <= '0;
            st_ack_q  <= 1'b0;
            kw_ack_q  <= 1'b0;
            st_done_q <= 1'b0;
            kw_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            work_q    <= work_d;
            st_out_q  <= st_out_d;
            kw_out_q  <= kw_out_d;
            st_ack_q  <= st_ack_d;
            kw_ack_q  <= kw_ack_d;
            st_done_q <= st_done_d;
            kw_done_q <= kw_done_d;
        end
    end

    assign st_ack  = st_ack_q;
    assign kw_ack  = kw_ack_q;
    assign st_done = st_done_q;
    assign kw_done = kw_done_q;
    assign st_out  = st_out_q;
    assign kw_out  = kw_out_q;
    assign busy    = state_q != IDLE;
endmodule
